// File: rtl/tslot_scheduler.sv
// Time-slot scheduler: splits each emulated period into NUM_SLOTS equal client
// slots plus an optional settle window, with masked per-slot enables and ticks.
module tslot_scheduler #(
  parameter int NUM_SLOTS     = 3,
  parameter int SLOT_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int TICK_OFFSET   = 0,
  parameter int PERIOD_W      = 16
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           en_in,
  input  logic [NUM_SLOTS-1:0]           slot_mask_in,
  output logic [NUM_SLOTS-1:0]           active_out,
  output logic [NUM_SLOTS-1:0]           tick_out,
  output logic [$clog2(NUM_SLOTS+1)-1:0] slot_out,
  output logic                           settle_out,
  output logic                           period_start_out,
  output logic                           busy_out,
  output logic [PERIOD_W-1:0]            period_count_out
);

  // state  | meaning
  // IDLE   | stopped; waits for en_in
  // SLOT   | serving slot slot_q, phase_q counts 0..SLOT_CYCLES-1
  // SETTLE | settle window after the last slot, down-counter settle_q

  localparam int SLOT_W = $clog2(NUM_SLOTS + 1);
  localparam int PH_W   = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int ST_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SLOT_CYCLES - 1);
  localparam logic [PH_W-1:0]   PH_TICK   = PH_W'(TICK_OFFSET);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [SLOT_W-1:0] SLOT_STL  = SLOT_W'(NUM_SLOTS);
  localparam logic [ST_W-1:0]   ST_LOAD   = ST_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  if (NUM_SLOTS < 1) begin : g_bad_num_slots
    $error("tslot_scheduler: NUM_SLOTS must be at least 1");
  end
  if (TICK_OFFSET >= SLOT_CYCLES) begin : g_bad_tick_offset
    $error("tslot_scheduler: TICK_OFFSET must be below SLOT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, SLOT, SETTLE} state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [ST_W-1:0]     settle_q, settle_d;
  logic [NUM_SLOTS-1:0] mask_q, mask_d;
  logic [PERIOD_W-1:0] count_d;
  logic                boundary;
  logic                start_d;
  logic [NUM_SLOTS-1:0] active_d;
  logic [NUM_SLOTS-1:0] tick_d;
  logic [SLOT_W-1:0]   slot_out_d;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    phase_d  = phase_q;
    settle_d = settle_q;
    mask_d   = mask_q;
    count_d  = period_count_out;
    boundary = 1'b0;

    case (state_q)
      IDLE: begin
        if (en_in) begin
          state_d = SLOT;
          slot_d  = '0;
          phase_d = '0;
        end
      end
      SLOT: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (slot_q == SLOT_LAST) begin
            if (SETTLE_CYCLES > 0) begin
              state_d  = SETTLE;
              settle_d = ST_LOAD;
            end else begin
              boundary = 1'b1;
            end
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      SETTLE: begin
        if (settle_q == '0) boundary = 1'b1;
        else                settle_d = settle_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Last cycle of the period: count it and decide whether to run another.
    if (boundary) begin
      count_d = period_count_out + 1'b1;
      slot_d  = '0;
      phase_d = '0;
      state_d = en_in ? SLOT : IDLE;
    end

    // Mask is sampled on the edge that enters slot 0 cycle 0 so it covers that cycle too.
    start_d = (state_d == SLOT) && (slot_d == '0) && (phase_d == '0);
    if (start_d) mask_d = slot_mask_in;

    active_d = '0;
    if (state_d == SLOT) active_d = mask_d & (NUM_SLOTS'(1) << slot_d);
    tick_d = (phase_d == PH_TICK) ? active_d : '0;

    slot_out_d = '0;
    if (state_d == SLOT)        slot_out_d = slot_d;
    else if (state_d == SETTLE) slot_out_d = SLOT_STL;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q          <= IDLE;
      slot_q           <= '0;
      phase_q          <= '0;
      settle_q         <= '0;
      mask_q           <= '0;
      active_out       <= '0;
      tick_out         <= '0;
      slot_out         <= '0;
      settle_out       <= 1'b0;
      period_start_out <= 1'b0;
      busy_out         <= 1'b0;
      period_count_out <= '0;
    end else begin
      state_q          <= state_d;
      slot_q           <= slot_d;
      phase_q          <= phase_d;
      settle_q         <= settle_d;
      mask_q           <= mask_d;
      active_out       <= active_d;
      tick_out         <= tick_d;
      slot_out         <= slot_out_d;
      settle_out       <= (state_d == SETTLE);
      period_start_out <= start_d;
      busy_out         <= (state_d != IDLE);
      period_count_out <= count_d;
    end
  end

endmodule

// File: tb/tb_tslot_scheduler.sv
// Scoreboard bench for tslot_scheduler: a default instance and a 4-slot,
// no-settle, 4-bit-counter instance run side by side.
module tb_tslot_scheduler;

  typedef struct {
    logic [3:0] tick;
    int         pos;
  } tk_t;

  typedef struct {
    int cnt;
    int gap;
  } ps_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: defaults
  logic        rst_n, en_a;
  logic [2:0]  mask_a, act_a, tick_a;
  logic [1:0]  slot_a;
  logic        settle_a, ps_a, busy_a;
  logic [15:0] cnt_a;

  // Instance B: 4 slots x 4 cycles, no settle, tick on phase 3, 4-bit counter
  logic        rst_b_n, en_b;
  logic [3:0]  mask_b, act_b, tick_b;
  logic [2:0]  slot_b;
  logic        settle_b, ps_b, busy_b;
  logic [3:0]  cnt_b;

  tslot_scheduler u_dut_a (
    .clk_in           (clk),
    .rst_in           (rst_n),
    .en_in            (en_a),
    .slot_mask_in     (mask_a),
    .active_out       (act_a),
    .tick_out         (tick_a),
    .slot_out         (slot_a),
    .settle_out       (settle_a),
    .period_start_out (ps_a),
    .busy_out         (busy_a),
    .period_count_out (cnt_a)
  );

  tslot_scheduler #(
    .NUM_SLOTS     (4),
    .SLOT_CYCLES   (4),
    .SETTLE_CYCLES (0),
    .TICK_OFFSET   (3),
    .PERIOD_W      (4)
  ) u_dut_b (
    .clk_in           (clk),
    .rst_in           (rst_b_n),
    .en_in            (en_b),
    .slot_mask_in     (mask_b),
    .active_out       (act_b),
    .tick_out         (tick_b),
    .slot_out         (slot_b),
    .settle_out       (settle_b),
    .period_start_out (ps_b),
    .busy_out         (busy_b),
    .period_count_out (cnt_b)
  );

  tk_t q_tk_a[$], q_tk_b[$];
  ps_t q_ps_a[$], q_ps_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_a(input int cnt, input int gap, input logic [2:0] m);
    ps_t p;
    tk_t t;
    p.cnt = cnt;
    p.gap = gap;
    q_ps_a.push_back(p);
    for (int i = 0; i < 3; i++) begin
      if (m[i]) begin
        t.tick = 4'(1 << i);
        t.pos  = i * 8;
        q_tk_a.push_back(t);
      end
    end
  endtask

  task automatic push_b(input int cnt, input int gap);
    ps_t p;
    tk_t t;
    p.cnt = cnt;
    p.gap = gap;
    q_ps_b.push_back(p);
    for (int i = 0; i < 4; i++) begin
      t.tick = 4'(1 << i);
      t.pos  = 4 * i + 3;
      q_tk_b.push_back(t);
    end
  endtask

  // Monitors: position is counted from the last period_start pulse.
  int  pos_a = 0, last_a = 0, pos_b = 0, last_b = 0;
  ps_t e_ps_a, e_ps_b;
  tk_t e_tk_a, e_tk_b;
  logic b_settle_seen = 1'b0;

  always @(negedge clk) begin
    if (ps_a) begin
      pos_a = 0;
      if (q_ps_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected_start: got start expected none (t=%0t)", $time);
      end else begin
        e_ps_a = q_ps_a.pop_front();
        check("a_start_count", cnt_a, e_ps_a.cnt);
        if (e_ps_a.gap != 0) check("a_start_gap", cyc - last_a, e_ps_a.gap);
      end
      last_a = cyc;
    end else begin
      pos_a++;
    end
    if (tick_a != 3'b000) begin
      if (q_tk_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected_tick: got %b expected none (t=%0t)", tick_a, $time);
      end else begin
        e_tk_a = q_tk_a.pop_front();
        check("a_tick_vec", {1'b0, tick_a}, e_tk_a.tick);
        check("a_tick_pos", pos_a, e_tk_a.pos);
      end
    end
  end

  always @(negedge clk) begin
    if (settle_b) b_settle_seen = 1'b1;
    if (ps_b) begin
      pos_b = 0;
      if (q_ps_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected_start: got start expected none (t=%0t)", $time);
      end else begin
        e_ps_b = q_ps_b.pop_front();
        check("b_start_count", cnt_b, e_ps_b.cnt);
        if (e_ps_b.gap != 0) check("b_start_gap", cyc - last_b, e_ps_b.gap);
      end
      last_b = cyc;
    end else begin
      pos_b++;
    end
    if (tick_b != 4'b0000) begin
      if (q_tk_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected_tick: got %b expected none (t=%0t)", tick_b, $time);
      end else begin
        e_tk_b = q_tk_b.pop_front();
        check("b_tick_vec", tick_b, e_tk_b.tick);
        check("b_tick_pos", pos_b, e_tk_b.pos);
      end
    end
  end

  task automatic run_a();
    // Full-mask free running, then en dropped at slot 1 phase 3
    mask_a = 3'b111;
    en_a   = 1'b1;
    push_a(0, 0, 3'b111);
    for (int k = 1; k <= 4; k++) push_a(k, 25, 3'b111);
    @(posedge clk); #1;
    check("a_first_start", ps_a, 1);
    check("a_slot0_active", act_a, 3'b001);
    check("a_slot0_tick", tick_a, 3'b001);
    check("a_slot0_busy", busy_a, 1);
    repeat (8) @(posedge clk); #1;
    check("a_slot1_active", act_a, 3'b010);
    check("a_slot1_index", slot_a, 1);
    repeat (16) @(posedge clk); #1;
    check("a_settle_flag", settle_a, 1);
    check("a_settle_active", act_a, 3'b000);
    check("a_settle_index", slot_a, 3);
    repeat (76) @(posedge clk); #1;
    check("a_count_after_100", cnt_a, 4);
    repeat (11) @(posedge clk); #1;
    en_a = 1'b0;
    repeat (13) @(posedge clk); #1;
    check("a_stop_settle", settle_a, 1);
    @(posedge clk); #1;
    check("a_stop_busy", busy_a, 0);
    check("a_stop_slot", slot_a, 0);
    check("a_stop_count", cnt_a, 5);
    repeat (30) @(posedge clk); #1;
    check("a_idle_tick", tick_a, 3'b000);

    // Mask change 111 -> 101 inside slot 0
    push_a(5, 0, 3'b111);
    push_a(6, 25, 3'b101);
    en_a = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk); #1;
    mask_a = 3'b101;
    repeat (22) @(posedge clk); #1;
    check("a_mask_next_start", ps_a, 1);
    repeat (10) @(posedge clk); #1;
    check("a_masked_slot_active", act_a, 3'b000);
    check("a_masked_slot_index", slot_a, 1);
    en_a = 1'b0;
    repeat (15) @(posedge clk); #1;
    check("a_mask_end_busy", busy_a, 0);
    check("a_mask_end_count", cnt_a, 7);

    // Asynchronous reset in the middle of slot 2
    mask_a = 3'b111;
    push_a(7, 0, 3'b111);
    push_a(0, 0, 3'b111);
    en_a = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("a_rst_active", act_a, 0);
    check("a_rst_busy", busy_a, 0);
    check("a_rst_count", cnt_a, 0);
    check("a_rst_slot", slot_a, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    check("a_release_idle", busy_a, 0);
    @(posedge clk); #1;
    check("a_restart_start", ps_a, 1);
    check("a_restart_active", act_a, 3'b001);
    check("a_restart_count", cnt_a, 0);
    en_a = 1'b0;
    repeat (25) @(posedge clk); #1;
    check("a_restart_end_busy", busy_a, 0);
    check("a_restart_end_count", cnt_a, 1);
  endtask

  task automatic run_b();
    en_b = 1'b1;
    push_b(0, 0);
    for (int k = 1; k <= 16; k++) push_b(k % 16, 16);
    @(posedge clk); #1;
    check("b_first_start", ps_b, 1);
    check("b_first_slot", slot_b, 0);
    repeat (3) @(posedge clk); #1;
    check("b_first_tick", tick_b, 4'b0001);
    check("b_first_active", act_b, 4'b0001);
    repeat (253) @(posedge clk); #1;
    check("b_wrap_count", cnt_b, 0);
    check("b_wrap_start", ps_b, 1);
    en_b = 1'b0;
    repeat (16) @(posedge clk); #1;
    check("b_after_wrap_count", cnt_b, 1);
    check("b_after_wrap_busy", busy_b, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    rst_b_n = 1'b0;
    en_a    = 1'b0;
    en_b    = 1'b0;
    mask_a  = 3'b000;
    mask_b  = 4'b1111;
    #12;
    check("a_reset_active", act_a, 0);
    check("a_reset_tick", tick_a, 0);
    check("a_reset_busy", busy_a, 0);
    check("a_reset_count", cnt_a, 0);
    check("a_reset_flags", {settle_a, ps_a, slot_a}, 0);
    check("b_reset_all", {act_b, tick_b, slot_b, settle_b, ps_b, busy_b, cnt_b}, 0);
    @(posedge clk); #2;
    rst_n   = 1'b1;
    rst_b_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("a_idle_busy", busy_a, 0);
    check("a_idle_active", act_a, 0);
    fork
      run_a();
      run_b();
    join
    repeat (3) @(posedge clk); #1;
    check("a_tick_queue_left", q_tk_a.size(), 0);
    check("a_start_queue_left", q_ps_a.size(), 0);
    check("b_tick_queue_left", q_tk_b.size(), 0);
    check("b_start_queue_left", q_ps_b.size(), 0);
    check("b_no_settle", b_settle_seen, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tslot_scheduler.md
Name: tslot_scheduler

Overview:
- Parametrised time-slot scheduler that divides each emulated T-cycle period into NUM_SLOTS equal slots plus a settle window.
- Generalises the fixed 25-cycle CPU/PPU/MEM/SETTLE duty cycling used at top level.
- Drives per-slot one-hot active enables and single-cycle tick strobes for the CPU, PPU and memory blocks.
- Adds graceful start/stop, per-slot masking latched at period start, and a completed-period counter.

Parameters:
- NUM_SLOTS, 3, number of client slots per period (>=1).
- SLOT_CYCLES, 8, clk_in cycles per slot (>=1).
- SETTLE_CYCLES, 1, clk_in cycles of settle window after the last slot (>=0; 0 means no settle).
- TICK_OFFSET, 0, cycle within a slot on which that slot's tick fires (0..SLOT_CYCLES-1).
- PERIOD_W, 16, width of the completed-period counter.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- en_in  input  1  run request; sampled in IDLE and at each period boundary.
- slot_mask_in  input  NUM_SLOTS  per-slot enable; latched on slot 0 cycle 0.
- active_out  output  NUM_SLOTS  one-hot: the current slot, gated by the latched mask.
- tick_out  output  NUM_SLOTS  one-cycle strobe on the current slot's TICK_OFFSET cycle, gated by the latched mask.
- slot_out  output  $clog2(NUM_SLOTS+1)  current slot index; NUM_SLOTS during SETTLE; 0 in IDLE.
- settle_out  output  1  high during the settle window.
- period_start_out  output  1  high on slot 0 cycle 0.
- busy_out  output  1  low only in IDLE.
- period_count_out  output  PERIOD_W  number of completed periods.

Behaviour:
- All outputs are registered. While rst_in=0 (asynchronous), and after release, every output is 0, state is IDLE, and the latched mask is 0.
- States:
  - IDLE: holds while en_in=0. When en_in=1 is sampled, the next cycle shows slot 0 cycle 0 (1-cycle latency).
  - SLOT: phase counter runs 0..SLOT_CYCLES-1. On the last phase the slot index increments. After the last phase of slot NUM_SLOTS-1, go to SETTLE, or directly to the boundary if SETTLE_CYCLES=0.
  - SETTLE: lasts exactly SETTLE_CYCLES cycles; active_out=0, settle_out=1.
- Period length is NUM_SLOTS*SLOT_CYCLES + SETTLE_CYCLES cycles (25 at defaults).
- Period boundary (the last cycle of the period):
  - period_count_out increments on the following cycle and wraps at 2^PERIOD_W.
  - en_in is sampled on this cycle: if 1, the next cycle is slot 0 cycle 0; if 0, the next cycle is IDLE.
- Deassertion of en_in mid-period has no effect until the boundary; the period always completes.
- slot_mask_in is captured on slot 0 cycle 0 and applies to that whole period. Mid-period mask changes take effect the next period.
- A masked slot still consumes its SLOT_CYCLES; only its active/tick bits are suppressed. Period length is invariant.
- active_out[i] = in SLOT, slot==i, latched mask[i].
- tick_out[i] = active_out[i] && phase==TICK_OFFSET.
  - Exactly one tick per unmasked slot per period.
  - With SLOT_CYCLES=1, the tick coincides with the only active cycle.
- When NUM_SLOTS=1, slot_out stays 0 and the slot counter wraps immediately.
- Reset asserted mid-operation aborts at once: all outputs are 0, the counter clears, and the block restarts from IDLE.
- Elaboration must fail (assertion) if TICK_OFFSET>=SLOT_CYCLES or NUM_SLOTS=0.

Test Plan:
- Defaults, mask=3'b111, en_in held 1 after reset → period_start_out every 25 cycles.
  - active_out = 001 for 8 cycles, 010 for 8, 100 for 8, then settle_out=1 for 1 cycle.
  - tick_out[i] pulses on the first cycle of each slot.
  - period_count_out reaches 4 after 100 cycles of running.
- en_in dropped at slot 1 phase 3 → the period completes (settle seen), then busy_out=0.
  - period_count_out increments once; slot_out=0.
  - No further ticks while en_in=0.
- mask changed from 111 to 101 in the middle of slot 0 → the current period still gives 3 ticks.
  - The next period gives ticks only on slots 0 and 2; slot 1's 8 cycles are still spent with active_out=0.
- NUM_SLOTS=4, SLOT_CYCLES=4, SETTLE_CYCLES=0, TICK_OFFSET=3 → period is 16 cycles with no settle_out.
  - tick_out[k] fires at period cycle 4k+3.
- rst_in pulsed low asynchronously mid slot 2 (no clock edge) → outputs go 0 immediately.
  - After release with en_in=1, slot 0 cycle 0 appears 1 cycle after the first sampled edge.
- PERIOD_W=4, 17 periods run → period_count_out wraps to 0 after 16 periods, then reads 1.
